// File: rtl/pipe_pkg.sv
// pipe_pkg: shared state encoding, control-bubble default and stall-counter width for pipeline stage registers
package pipe_pkg;
  typedef enum logic [1:0] {EMPTY = 2'b00, ONE = 2'b01, FULL = 2'b10} state_t;
  localparam logic CTRL_NOP_BIT = 1'b0;
  localparam int STALL_CNT_W = 32;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: width-parametrised saturating up-counter with synchronous active-low clear
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         clr_n,
  input  logic         en,
  output logic [W-1:0] count
);
  always_ff @(posedge clk) begin
    if (!clr_n) count <= '0;
    else if (en && count != '1) count <= count + 1'b1;
  end
endmodule

// File: rtl/pipe_stage_elastic_reg.sv
// pipe_stage_elastic_reg: elastic valid/ready stage register with 2-entry skid, flush and NOP bubbles
// Optional stall-cycle counter output StallCount enabled by PIPE_STAGE_STALL_CNT_EN.
module pipe_stage_elastic_reg
  import pipe_pkg::*;
#(
  parameter int                DATA_W   = 192,
  parameter int                CTRL_W   = 40,
  parameter logic [CTRL_W-1:0] CTRL_NOP = {CTRL_W{CTRL_NOP_BIT}}
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              Flush,
  input  logic              InValid,
  output logic              InReady,
  input  logic [DATA_W-1:0] DataIn,
  input  logic [CTRL_W-1:0] CtrlIn,
  output logic              OutValid,
  input  logic              OutReady,
  output logic [DATA_W-1:0] DataOut,
  output logic [CTRL_W-1:0] CtrlOut
`ifdef PIPE_STAGE_STALL_CNT_EN
  ,
  output logic [STALL_CNT_W-1:0] StallCount
`endif
);
  state_t            state, nxt;
  logic [DATA_W-1:0] main_data, skid_data;
  logic [CTRL_W-1:0] main_ctrl, skid_ctrl;
  logic              in_fire, out_fire;
  assign OutValid = state != EMPTY;
  assign DataOut  = main_data;
  assign CtrlOut  = OutValid ? main_ctrl : CTRL_NOP;
  assign in_fire  = InValid & InReady;
  assign out_fire = OutValid & OutReady;
  always_comb begin
    nxt = state == EMPTY ? (in_fire ? ONE : EMPTY) :
          state == ONE   ? (in_fire && !out_fire ? FULL : !in_fire && out_fire ? EMPTY : ONE) :
                           (out_fire ? ONE : FULL);
  end
  // InReady is a pure function of the next state, so it never depends combinationally on OutReady
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state     <= EMPTY;
      InReady   <= 1'b0;
      main_data <= '0;
      skid_data <= '0;
      main_ctrl <= CTRL_NOP;
      skid_ctrl <= CTRL_NOP;
    end else if (Flush) begin
      state     <= EMPTY;
      InReady   <= 1'b1;
      main_ctrl <= CTRL_NOP;
      skid_ctrl <= CTRL_NOP;
    end else begin
      state   <= nxt;
      InReady <= nxt != FULL;
      if (state == FULL && out_fire) begin
        main_data <= skid_data;
        main_ctrl <= skid_ctrl;
      end else if (in_fire && (state == EMPTY || out_fire)) begin
        main_data <= DataIn;
        main_ctrl <= CtrlIn;
      end
      if (in_fire && state == ONE && !out_fire) begin
        skid_data <= DataIn;
        skid_ctrl <= CtrlIn;
      end
    end
  end
`ifdef PIPE_STAGE_STALL_CNT_EN
  sat_counter #(.W(STALL_CNT_W)) u_stall_cnt (
    .clk  (Clk),
    .clr_n(Rst_n),
    .en   (OutValid & ~OutReady),
    .count(StallCount)
  );
`endif
endmodule

// File: tb/tb_pipe_stage_elastic_reg.sv
// tb_pipe_stage_elastic_reg: directed plus randomized check of the elastic stage against a queue model
module tb_pipe_stage_elastic_reg;
  localparam int DW = 32;
  localparam int CW = 8;
  localparam logic [CW-1:0] NOP = 8'hA5;
  typedef struct packed {logic [DW-1:0] d; logic [CW-1:0] c;} ent_t;
  logic clk = 0, rst_n = 0, flush = 0, in_valid = 0, out_ready = 0;
  logic in_ready, out_valid;
  logic [DW-1:0] data_in = '0, data_out;
  logic [CW-1:0] ctrl_in = '0, ctrl_out;
  int checks = 0, failures = 0;
  ent_t q[$];
  logic ready_m = 0, seen_rst = 0;
  logic [DW-1:0] last_m = '0;
`ifdef PIPE_STAGE_STALL_CNT_EN
  logic [31:0] stall_count, cnt_m = '0;
`endif
  pipe_stage_elastic_reg #(.DATA_W(DW), .CTRL_W(CW), .CTRL_NOP(NOP)) dut (
    .Clk(clk), .Rst_n(rst_n), .Flush(flush), .InValid(in_valid), .InReady(in_ready),
    .DataIn(data_in), .CtrlIn(ctrl_in), .OutValid(out_valid), .OutReady(out_ready),
    .DataOut(data_out), .CtrlOut(ctrl_out)
`ifdef PIPE_STAGE_STALL_CNT_EN
    , .StallCount(stall_count)
`endif
  );
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", n, a, e, $time);
    end
  endtask
  // Reference: a FIFO of at most two entries; accept only when the previous cycle left room
  always @(posedge clk) begin
    logic inf, outf;
    inf  = in_valid && ready_m;
    outf = q.size() != 0 && out_ready;
`ifdef PIPE_STAGE_STALL_CNT_EN
    if (!rst_n) cnt_m = 0;
    else if (q.size() != 0 && !out_ready && cnt_m != 32'hFFFF_FFFF) cnt_m = cnt_m + 1;
`endif
    if (!rst_n) begin
      q.delete(); ready_m = 0; last_m = '0; seen_rst = 1;
    end else if (flush) begin
      q.delete(); ready_m = 1;
    end else begin
      if (outf) void'(q.pop_front());
      if (inf) q.push_back('{data_in, ctrl_in});
      ready_m = q.size() < 2;
      if (q.size() != 0) last_m = q[0].d;
    end
  end
  always @(negedge clk) if (seen_rst) begin
    chk("m_out_valid", 64'(out_valid), 64'(q.size() != 0));
    chk("m_in_ready", 64'(in_ready), 64'(ready_m));
    chk("m_ctrl_out", 64'(ctrl_out), 64'(q.size() != 0 ? q[0].c : NOP));
    chk("m_data_out", 64'(data_out), 64'(q.size() != 0 ? q[0].d : last_m));
`ifdef PIPE_STAGE_STALL_CNT_EN
    chk("m_stall_count", 64'(stall_count), 64'(cnt_m));
`endif
  end
  task automatic tick(); @(negedge clk); endtask
  task automatic put(input logic v, input logic [DW-1:0] d, input logic r);
    in_valid = v; data_in = d; ctrl_in = d[CW-1:0] ^ 8'h3C; out_ready = r;
  endtask
  initial begin
    rst_n = 0; tick(); tick();
    chk("rst_out_valid", 64'(out_valid), 0);
    chk("rst_ctrl", 64'(ctrl_out), 64'(NOP));
    chk("rst_in_ready", 64'(in_ready), 0);
    chk("rst_data", 64'(data_out), 0);
    rst_n = 1; tick();
    chk("rel_in_ready", 64'(in_ready), 1);
    for (int i = 1; i <= 8; i++) begin
      put(1, DW'(i), 1); tick();
      chk("stream_data", 64'(data_out), 64'(i));
      chk("stream_valid", 64'(out_valid), 1);
      chk("stream_ready", 64'(in_ready), 1);
    end
    put(0, 0, 1); tick();
    chk("drain_valid", 64'(out_valid), 0);
    put(1, 32'hA, 0); tick();
    put(1, 32'hB, 0); tick();
    chk("full_ready", 64'(in_ready), 0);
    chk("full_data", 64'(data_out), 32'hA);
    chk("full_ctrl", 64'(ctrl_out), 64'(8'h0A ^ 8'h3C));
    put(0, 0, 1); tick();
    chk("skid_data", 64'(data_out), 32'hB);
    chk("skid_ready", 64'(in_ready), 1);
    tick();
    chk("skid_empty", 64'(out_valid), 0);
    put(1, 32'hA, 0); tick();
    put(1, 32'hB, 0); tick();
    put(1, 32'hC, 0); flush = 1; tick();
    flush = 0;
    chk("flush_valid", 64'(out_valid), 0);
    chk("flush_ctrl", 64'(ctrl_out), 64'(NOP));
    chk("flush_ready", 64'(in_ready), 1);
    chk("flush_data_hold", 64'(data_out), 32'hA);
    put(0, 0, 1); tick();
    chk("flush_no_c", 64'(out_valid), 0);
    put(1, 32'h55, 0); tick();
    chk("one_valid", 64'(out_valid), 1);
    put(1, 32'h66, 0); rst_n = 0; flush = 1; tick();
    rst_n = 1; flush = 0;
    chk("rstfl_ready", 64'(in_ready), 0);
    chk("rstfl_valid", 64'(out_valid), 0);
    chk("rstfl_data", 64'(data_out), 0);
    put(0, 0, 0); tick();
`ifdef PIPE_STAGE_STALL_CNT_EN
    put(1, 32'h77, 0); tick();
    put(0, 0, 0);
    repeat (5) tick();
    chk("stall_5", 64'(stall_count), 5);
    out_ready = 1; flush = 1; tick();
    flush = 0;
    chk("stall_flush", 64'(stall_count), 5);
    rst_n = 0; tick();
    rst_n = 1;
    chk("stall_rst", 64'(stall_count), 0);
`endif
    for (int i = 0; i < 3000; i++) begin
      put($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 2) != 0);
      flush = $urandom_range(0, 39) == 0;
      rst_n = $urandom_range(0, 199) != 0;
      tick();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
